// File: rtl/accumulator_bank.sv
// rtl/accumulator_bank.sv - multi-row column accumulator with a serialised, handshaked row drain
// Optional ACC_SATURATE_EN: saturating signed adds plus a sticky sat_flag output.
module accumulator_bank #(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ACC_DEPTH   = 4,
    parameter int ADDR_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            acc_valid,
    input  logic [$clog2(ACC_DEPTH)-1:0]    acc_row,
    input  logic                            acc_first,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
    input  logic                            drain_req,
    input  logic [$clog2(ACC_DEPTH)-1:0]    drain_row,
    input  logic [ADDR_W-1:0]               drain_base_addr,
    output logic                            drain_busy,
    output logic                            drain_done,
    output logic [VERTICAL_BW-1:0]          output_data,
    output logic [ADDR_W-1:0]               output_buffer_addr,
    output logic                            output_buffer_enable,
    input  logic                            output_buffer_ready
`ifdef ACC_SATURATE_EN
    ,
    output logic                            sat_flag
`endif
);
    localparam int               COL_W    = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARR_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [VERTICAL_BW-1:0] rows_q [ACC_DEPTH][ARR_SIZE];
    logic [VERTICAL_BW-1:0] rows_d [ACC_DEPTH][ARR_SIZE];
    logic [VERTICAL_BW-1:0] snap_q [ARR_SIZE];
    logic [VERTICAL_BW-1:0] snap_d [ARR_SIZE];
    logic                   start;
    logic [VERTICAL_BW-1:0] in_w, sum_w;

`ifdef ACC_SATURATE_EN
    localparam int                     MSB   = VERTICAL_BW - 1;
    localparam logic [VERTICAL_BW-1:0] SMAX  = {1'b0, {(VERTICAL_BW-1){1'b1}}};
    localparam logic [VERTICAL_BW-1:0] SMIN  = {1'b1, {(VERTICAL_BW-1){1'b0}}};
    logic                              sat_hit;
    logic                              sat_q;
`endif

    assign start = (state_q == IDLE) && drain_req;

    // Row update: a starting drain clears its row, and a same-edge accumulate into
    // that row lands on the cleared value, so it behaves as a first pass.
    always_comb begin
        rows_d = rows_q;
        snap_d = snap_q;
        in_w   = '0;
        sum_w  = '0;
`ifdef ACC_SATURATE_EN
        sat_hit = 1'b0;
`endif
        if (start) begin
            for (int c = 0; c < ARR_SIZE; c++) begin
                snap_d[c]            = rows_q[drain_row][c];
                rows_d[drain_row][c] = '0;
            end
        end
        if (acc_valid) begin
            for (int c = 0; c < ARR_SIZE; c++) begin
                in_w  = accumulated_val[c*VERTICAL_BW +: VERTICAL_BW];
                sum_w = rows_q[acc_row][c] + in_w;
`ifdef ACC_SATURATE_EN
                if ((rows_q[acc_row][c][MSB] == in_w[MSB]) && (sum_w[MSB] != in_w[MSB])) begin
                    sum_w = in_w[MSB] ? SMIN : SMAX;
                    if (!acc_first && !(start && (acc_row == drain_row))) begin
                        sat_hit = 1'b1;
                    end
                end
`endif
                if (acc_first || (start && (acc_row == drain_row))) begin
                    rows_d[acc_row][c] = in_w;
                end else begin
                    rows_d[acc_row][c] = sum_w;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                    col_d   = '0;
                    base_d  = drain_base_addr;
                end
            end
            DRAIN: begin
                if (output_buffer_ready) begin
                    if (col_q == LAST_COL) begin
                        state_d = DONE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            base_q  <= '0;
            for (int c = 0; c < ARR_SIZE; c++) begin
                snap_q[c] <= '0;
            end
            for (int r = 0; r < ACC_DEPTH; r++) begin
                for (int c = 0; c < ARR_SIZE; c++) begin
                    rows_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
            snap_q  <= snap_d;
            rows_q  <= rows_d;
        end
    end

`ifdef ACC_SATURATE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (sat_hit) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_flag = sat_q;
`endif

    assign drain_busy           = (state_q == DRAIN);
    assign drain_done           = (state_q == DONE);
    assign output_buffer_enable = drain_busy;
    assign output_data          = drain_busy ? snap_q[col_q] : '0;
    assign output_buffer_addr   = drain_busy ? (base_q + ADDR_W'(col_q)) : '0;

endmodule
